// File: rtl/note_recorder.sv
// Note recorder: synchronizes and debounces 8 note keys,
// queues one encoded note per accepted press in a small FIFO.
module note_recorder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DEPTH           = 8
) (
  input  logic       input_clock1_1,
  input  logic       input_reset_n1_2,
  input  logic [7:0] input_keys_3,
  input  logic       input_read_ready_4,
  output logic [2:0] output_note_code_5,
  output logic       output_note_valid_6,
  output logic       output_fifo_full_7,
  output logic       output_overflow_8,
  output logic [3:0] output_count_9
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DEB  = 2'd1;
  localparam logic [1:0] S_HELD = 2'd2;
  localparam logic [1:0] S_REL  = 2'd3;

  localparam logic [3:0] DC     = 4'(DEBOUNCE_CYCLES);
  localparam logic [3:0] CDEPTH = 4'(DEPTH);
  localparam logic [AW-1:0] ONE = AW'(1);

  logic [7:0]    sync1_q;
  logic [7:0]    sync2_q;
  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic [7:0]    pat_q;
  logic [7:0]    pat_d;
  logic [3:0]    cnt_q;
  logic [3:0]    cnt_d;
  logic          push;
  logic [2:0]    enc;

  logic [2:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW-1:0] rd_nx;
  logic [3:0]    count_q;
  logic [3:0]    count_d;
  logic [2:0]    code_q;
  logic [2:0]    code_d;
  logic          ovf_q;
  logic          pop;
  logic          full;
  logic          do_push;

  // Two-flop synchronizer for the asynchronous keys.
  always_ff @(posedge input_clock1_1 or negedge input_reset_n1_2) begin
    if (!input_reset_n1_2) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= input_keys_3;
      sync2_q <= sync1_q;
    end
  end

  // Lowest set key wins.
  always_comb begin
    enc = 3'd0;
    priority case (1'b1)
      pat_q[0]: enc = 3'd0;
      pat_q[1]: enc = 3'd1;
      pat_q[2]: enc = 3'd2;
      pat_q[3]: enc = 3'd3;
      pat_q[4]: enc = 3'd4;
      pat_q[5]: enc = 3'd5;
      pat_q[6]: enc = 3'd6;
      pat_q[7]: enc = 3'd7;
      default:  enc = 3'd0;
    endcase
  end

  // Press/release debounce; one push per accepted press.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sync2_q != 8'd0) begin
          pat_d   = sync2_q;
          cnt_d   = 4'd0;
          state_d = S_DEB;
        end
      end
      S_DEB: begin
        if (sync2_q != pat_q) begin
          state_d = S_IDLE;
        end else if (cnt_q == DC) begin
          push    = 1'b1;
          state_d = S_HELD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_HELD: begin
        if (sync2_q == 8'd0) begin
          cnt_d   = 4'd0;
          state_d = S_REL;
        end
      end
      S_REL: begin
        if (sync2_q != 8'd0) begin
          state_d = S_HELD;
        end else if (cnt_q == DC) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Debounce FSM registers.
  always_ff @(posedge input_clock1_1 or negedge input_reset_n1_2) begin
    if (!input_reset_n1_2) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
    end
  end

  assign full    = (count_q == CDEPTH);
  assign pop     = (count_q != 4'd0) && input_read_ready_4;
  assign do_push = push && (!full || pop);
  assign rd_nx   = rd_q + ONE;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_d = count_q;
    unique case ({do_push, pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  // Registered head: next-oldest on pop, new note into empty FIFO.
  always_comb begin
    code_d = code_q;
    if (pop) begin
      if (count_q > 4'd1) begin
        code_d = mem_q[rd_nx];
      end else if (do_push) begin
        code_d = enc;
      end
    end else if (do_push && count_q == 4'd0) begin
      code_d = enc;
    end
  end

  // FIFO storage, pointers and sticky overflow.
  always_ff @(posedge input_clock1_1 or negedge input_reset_n1_2) begin
    if (!input_reset_n1_2) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      code_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= enc;
        wr_q        <= wr_q + ONE;
      end
      if (pop) begin
        rd_q <= rd_nx;
      end
      if (push && full && !pop) begin
        ovf_q <= 1'b1;
      end
      count_q <= count_d;
      code_q  <= code_d;
    end
  end

  assign output_note_code_5  = code_q;
  assign output_note_valid_6 = (count_q != 4'd0);
  assign output_fifo_full_7  = full;
  assign output_overflow_8   = ovf_q;
  assign output_count_9      = count_q;

endmodule
